// File: rtl/console_rx_pkg.sv
// ---------------------------------------------------------------------------
// console_rx_pkg : shared register map, STATUS layout and receiver states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package console_rx_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_OVERRUN   = 1;
    localparam int STAT_FRAME_ERR = 2;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/console_rx_if.sv
// ---------------------------------------------------------------------------
// console_rx_if : device-port bus between the core (master) and console_rx
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface console_rx_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_in;
    logic                  we_in;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [DATA_WIDTH-1:0] wdata_in;
    logic [DATA_WIDTH-1:0] rdata_out;

    modport master (
        output req_in, we_in, addr_in, wdata_in,
        input  rdata_out
    );

    modport slave (
        input  req_in, we_in, addr_in, wdata_in,
        output rdata_out
    );
endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo : single-clock FIFO, same-cycle push+pop, registered empty flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_data,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_empty;

    logic             w_pop_ok;
    logic             w_push_ok;
    logic [CNT_W-1:0] w_count_next;

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign w_pop_ok     = i_pop && (r_count != '0);
    assign w_push_ok    = i_push && ((r_count != C_DEPTH) || w_pop_ok);
    assign w_count_next = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == C_DEPTH);
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/console_rx.sv
// ---------------------------------------------------------------------------
// console_rx : 8N1 serial receiver with RX FIFO and DATA/STATUS bus registers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module console_rx
    import console_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  wire logic    clk_in,
    input  wire logic    reset_in,
    input  wire logic    rx_in,
    console_rx_if.slave  bus,
    output logic         irq_out
);

    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int FCOUNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] C_HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] C_FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    // ---------------- synchroniser and edge detect ----------------
    logic       r_rx_meta;
    logic       r_rx_s;
    logic       r_rx_prev;
    logic [1:0] r_sync_fill;
    logic       w_fall;

    // r_rx_prev only goes high once the synchroniser holds real line samples,
    // so the reset value of 1 never fakes a falling edge on a low line.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_prev   <= 1'b0;
            r_sync_fill <= 2'b00;
        end else begin
            r_rx_meta   <= rx_in;
            r_rx_s      <= r_rx_meta;
            r_sync_fill <= {r_sync_fill[0], 1'b1};
            r_rx_prev   <= r_sync_fill[1] & r_rx_s;
        end
    end

    assign w_fall = r_rx_prev & ~r_rx_s;

    // ---------------- receiver FSM ----------------
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             w_tick;
    logic             w_push;
    logic             w_fe_set;

    assign w_tick   = (r_cnt == '0);
    assign w_push   = (r_state == STOP) && w_tick && r_rx_s;
    assign w_fe_set = (r_state == STOP) && w_tick && !r_rx_s;

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state <= START;
                        r_cnt   <= C_HALF_BIT;
                    end
                end
                START: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!r_rx_s) begin
                        r_state   <= DATA;
                        r_cnt     <= C_FULL_BIT;
                        r_bit_idx <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                DATA: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        r_cnt   <= C_FULL_BIT;
                        if (r_bit_idx == 3'd7) r_state   <= STOP;
                        else                   r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end
                STOP: begin
                    if (!w_tick) r_cnt   <= r_cnt - 1'b1;
                    else         r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]          w_head;
    logic                w_full;
    logic                w_empty;
    logic [FCOUNT_W-1:0] w_count;
    logic                w_pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_in),
        .rst     (!reset_in),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // ---------------- register decode ----------------
    logic [1:0]            w_sel;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_ov_set;
    logic                  w_ov_clr;
    logic                  w_fe_clr;
    logic [DATA_WIDTH-1:0] w_rdata_next;
    logic                  r_overrun;
    logic                  r_frame_err;
    logic [DATA_WIDTH-1:0] r_rdata;

    assign w_sel    = bus.addr_in[3:2];
    assign w_rd     = bus.req_in && !bus.we_in;
    assign w_wr     = bus.req_in && bus.we_in;
    assign w_pop    = w_rd && (w_sel == REG_DATA) && !w_empty;
    assign w_ov_set = w_push && w_full && !w_pop;
    assign w_ov_clr = w_wr && (w_sel == REG_STATUS) && bus.wdata_in[STAT_OVERRUN];
    assign w_fe_clr = w_wr && (w_sel == REG_STATUS) && bus.wdata_in[STAT_FRAME_ERR];

    always_comb begin
        w_rdata_next = '0;
        case (w_sel)
            REG_DATA: begin
                if (!w_empty) w_rdata_next[7:0] = w_head;
            end
            REG_STATUS: begin
                w_rdata_next[STAT_NOT_EMPTY] = !w_empty;
                w_rdata_next[STAT_OVERRUN]   = r_overrun;
                w_rdata_next[STAT_FRAME_ERR] = r_frame_err;
                w_rdata_next[STAT_COUNT_LSB +: FCOUNT_W] = w_count;
            end
            default: w_rdata_next = '0;
        endcase
    end

    // Sticky flags: a hardware set in the same cycle as a software clear wins.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_overrun   <= w_ov_set | (r_overrun & ~w_ov_clr);
            r_frame_err <= w_fe_set | (r_frame_err & ~w_fe_clr);
            if (w_rd) r_rdata <= w_rdata_next;
        end
    end

    assign bus.rdata_out = r_rdata;
    assign irq_out       = !w_empty;

    logic w_unused;
    assign w_unused = ^{bus.addr_in[ADDR_WIDTH-1:4], bus.addr_in[1:0],
                        bus.wdata_in[DATA_WIDTH-1:3], bus.wdata_in[0]};

endmodule

`default_nettype wire

// File: tb/tb_console_rx.sv
// ---------------------------------------------------------------------------
// tb_console_rx : directed + randomized bench with a queue-based receive model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_console_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic rx      = 1'b1;
    logic irq;

    console_rx_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    console_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32)
    ) dut (
        .clk_in   (clk),
        .reset_in (reset_n),
        .rx_in    (rx),
        .bus      (bus.slave),
        .irq_out  (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: received bytes plus the two sticky flags.
    logic [7:0] q[$];
    bit         m_ov = 1'b0;
    bit         m_fe = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s       = '0;
        s[0]    = (q.size() != 0);
        s[1]    = m_ov;
        s[2]    = m_fe;
        s[15:8] = 8'(q.size());
        return s;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ov = 1'b0;
        m_fe = 1'b0;
    endtask

    task automatic model_rx(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok)                m_fe = 1'b1;
        else if (q.size() < DEPTH)   q.push_back(b);
        else                         m_ov = 1'b1;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus.req_in  = 1'b1;
        bus.we_in   = 1'b0;
        bus.addr_in = addr;
        @(posedge clk);
        @(negedge clk);
        bus.req_in = 1'b0;
        data = bus.rdata_out;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.req_in   = 1'b1;
        bus.we_in    = 1'b1;
        bus.addr_in  = addr;
        bus.wdata_in = data;
        @(posedge clk);
        @(negedge clk);
        bus.req_in = 1'b0;
        bus.we_in  = 1'b0;
    endtask

    task automatic read_data_check(input string tag);
        logic [31:0] d;
        logic [31:0] exp;
        bus_read(32'h0, d);
        exp = (q.size() != 0) ? {24'h0, q.pop_front()} : 32'h0;
        check(tag, d, exp);
    endtask

    task automatic read_status_check(input string tag);
        logic [31:0] d;
        bus_read(32'h4, d);
        check(tag, d, m_status());
    endtask

    task automatic write_status(input logic [31:0] v);
        bus_write(32'h4, v);
        if (v[1]) m_ov = 1'b0;
        if (v[2]) m_fe = 1'b0;
    endtask

    // Drives one 8N1 frame starting on a falling clock edge, then a short idle gap.
    task automatic send_frame(input logic [7:0] b, input bit stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_model(input logic [7:0] b, input bit stop_ok);
        send_frame(b, stop_ok);
        model_rx(b, stop_ok);
    endtask

    task automatic check_irq(input string tag);
        check(tag, {31'h0, irq}, {31'h0, q.size() != 0});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] exp;
        logic [7:0]  b;

        bus.req_in   = 1'b0;
        bus.we_in    = 1'b0;
        bus.addr_in  = '0;
        bus.wdata_in = '0;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        model_reset();
        check("reset_rdata", bus.rdata_out, 32'h0);
        check_irq("reset_irq");
        read_status_check("reset_status");

        // 1: single byte
        send_model(8'hA5, 1'b1);
        read_status_check("t1_status");
        check("t1_status_abs", bus.rdata_out, 32'h0000_0101);
        check_irq("t1_irq");
        read_data_check("t1_data");
        read_status_check("t1_status_after");

        // 2: overrun on the fifth byte
        for (int i = 1; i <= 5; i++) send_model(8'(8'h11 * i), 1'b1);
        read_status_check("t2_status");
        check("t2_status_abs", bus.rdata_out, 32'h0000_0403);
        for (int i = 0; i < 5; i++) read_data_check("t2_data");
        write_status(32'h2);
        read_status_check("t2_cleared");
        check_irq("t2_irq");

        // 3: frame error
        send_model(8'h3C, 1'b0);
        read_status_check("t3_status");
        check("t3_status_abs", bus.rdata_out, 32'h0000_0004);
        check_irq("t3_irq");
        write_status(32'h4);
        read_status_check("t3_cleared");

        // 4: short glitch is not a start bit
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        read_status_check("t4_status");
        send_model(8'h5A, 1'b1);
        read_data_check("t4_after_glitch");

        // 5: pop in the very cycle the stop bit of a push into a full FIFO is sampled
        for (int i = 0; i < 4; i++) send_model(8'(8'hA1 + i), 1'b1);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (154) @(posedge clk);
                @(negedge clk);
                bus_read(32'h0, d);
            end
        join
        exp = {24'h0, q.pop_front()};
        q.push_back(8'hA5);
        check("t5_pop_data", d, exp);
        read_status_check("t5_status");
        check("t5_status_abs", bus.rdata_out, 32'h0000_0401);
        for (int i = 0; i < 4; i++) read_data_check("t5_drain");

        // 6: one-cycle reset mid-frame
        send_model(8'h99, 1'b1);
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (CPB * 6 + 8) @(negedge clk);
                reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
        join
        model_reset();
        read_status_check("t6_status");
        check_irq("t6_irq");
        send_model(8'h7E, 1'b1);
        read_status_check("t6_status_rx");
        read_data_check("t6_data");

        // Randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 11))
                0, 1, 2, 3, 4: begin
                    b = 8'($urandom);
                    send_model(b, $urandom_range(0, 5) != 0);
                    check_irq("rnd_irq_rx");
                end
                5, 6:    read_data_check("rnd_data");
                7:       read_status_check("rnd_status");
                8:       write_status({$urandom} & 32'h0000_0006);
                9: begin
                    bus_write(32'h0, $urandom);
                    read_status_check("rnd_data_wr_ignored");
                end
                10: begin
                    bus_write({28'h0, 2'($urandom_range(2, 3)), 2'b00}, 32'hFFFF_FFFF);
                    bus_read({28'h0, 2'($urandom_range(2, 3)), 2'b00}, d);
                    check("rnd_reserved", d, 32'h0);
                end
                default: check_irq("rnd_irq");
            endcase
        end
        read_status_check("final_status");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
